// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: state encoding, direction constants and default sizes for the shift sequencer
package shift_seq_pkg;
   localparam int WIDTH_DEF = 16;
   localparam int CNT_W_DEF = 5;
   localparam logic DIR_LEFT = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/shift_sequencer.sv
// shift_sequencer: accepts one shift command, optionally clears lrshifter, then clocks N serial fill bits into it
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] cmd_pattern,
   input  logic             cmd_clear,
   input  logic             abort,
   output logic             sh_reset,
   output logic             sh_load,
   output logic             sh_d,
   output logic             sh_dir,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] shift_cnt
);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
   state_t state;
   logic dir_q;
   logic abort_q;
   logic [WIDTH-1:0] pat_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_sat;
   logic [CNT_W-1:0] next_cnt;
   assign count_sat = (cmd_count > MAX_CNT) ? MAX_CNT : cmd_count;
   assign next_cnt = shift_cnt + CNT_W'(1);
   // FSM, command latch and shift counter; the pattern is shifted down so bit 0 is always the next fill bit
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         shift_cnt <= '0;
         dir_q <= DIR_LEFT;
         pat_q <= '0;
         count_q <= '0;
         abort_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               dir_q <= cmd_dir;
               pat_q <= cmd_pattern;
               count_q <= count_sat;
               shift_cnt <= '0;
               abort_q <= 1'b0;
               state <= cmd_clear ? CLEAR : ((count_sat != '0) ? SHIFT : DONE);
            end
            CLEAR: begin
               abort_q <= abort;
               state <= (abort || count_q == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
               shift_cnt <= next_cnt;
               pat_q <= pat_q >> 1;
               abort_q <= abort;
               if (abort || next_cnt == count_q) state <= DONE;
            end
            DONE: begin
               abort_q <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign cmd_ready = (state == IDLE);
   assign busy = !cmd_ready;
   assign done = (state == DONE);
   assign aborted = done && abort_q;
   assign sh_reset = (state == CLEAR);
   assign sh_load = (state == SHIFT);
   assign sh_d = sh_load && pat_q[0];
   assign sh_dir = sh_load ? dir_q : DIR_LEFT;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed scoreboard bench for shift_sequencer with a behavioural lrshifter model
module tb_shift_sequencer;
   import shift_seq_pkg::*;
   typedef struct {
      logic        dir;
      logic        clear;
      logic [15:0] pattern;
      int          loads;
      logic        ab;
      logic [15:0] out;
   } exp_t;
   logic clk = 0;
   logic reset = 0;
   logic cmd_valid = 0;
   logic cmd_dir = 0;
   logic cmd_clear = 0;
   logic abort = 0;
   logic [4:0] cmd_count = 0;
   logic [15:0] cmd_pattern = 0;
   logic cmd_ready, sh_reset, sh_load, sh_d, sh_dir, busy, done, aborted;
   logic [4:0] shift_cnt;
   logic [15:0] sh_q = 0;
   logic [15:0] exp_sh = 0;
   int vecs = 0;
   int errs = 0;
   exp_t sb[$];

   shift_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_count(cmd_count), .cmd_pattern(cmd_pattern),
      .cmd_clear(cmd_clear), .abort(abort), .sh_reset(sh_reset), .sh_load(sh_load),
      .sh_d(sh_d), .sh_dir(sh_dir), .busy(busy), .done(done), .aborted(aborted),
      .shift_cnt(shift_cnt)
   );

   always #5 clk = ~clk;

   // behavioural lrshifter fed by the sequencer outputs
   always @(posedge clk) begin
      if (sh_reset) sh_q <= '0;
      else if (sh_load) sh_q <= sh_dir ? {sh_d, sh_q[15:1]} : {sh_q[14:0], sh_d};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // push the predicted outcome, present the command and wait until the next edge accepts it
   task automatic issue(input logic d, input int cnt, input logic [15:0] pat, input logic clr,
                        input int ab_at, output int waited);
      exp_t e;
      int sat;
      sat = (cnt > 16) ? 16 : cnt;
      e.dir = d;
      e.clear = clr;
      e.pattern = pat;
      e.ab = (ab_at != 0 && ab_at <= sat);
      e.loads = e.ab ? ab_at : sat;
      if (clr) exp_sh = '0;
      for (int i = 0; i < e.loads; i++) exp_sh = d ? {pat[i], exp_sh[15:1]} : {exp_sh[14:0], pat[i]};
      e.out = exp_sh;
      sb.push_back(e);
      cmd_dir = d;
      cmd_count = 5'(cnt);
      cmd_pattern = pat;
      cmd_clear = clr;
      cmd_valid = 1;
      waited = 0;
      while (!cmd_ready && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) chk("accept_timeout", 0, 1);
   endtask

   // follow one accepted command to its done pulse and compare against the scoreboard entry
   task automatic watch(input int ab_at, input logic drop);
      exp_t e;
      int loads = 0;
      int clrs = 0;
      int n = 0;
      logic seen = 0;
      e = sb.pop_front();
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         abort = 0;
         if (drop) cmd_valid = 0;
         if (sh_reset) clrs++;
         if (sh_load) begin
            chk("shift_cnt_run", shift_cnt, loads);
            chk("sh_d", sh_d, e.pattern[loads]);
            chk("sh_dir", sh_dir, e.dir);
            loads++;
            if (loads == ab_at) abort = 1;
         end else chk("sh_d_idle", sh_d, 0);
         if (done) begin
            seen = 1;
            chk("aborted", aborted, e.ab);
            chk("shift_cnt_done", shift_cnt, e.loads);
            chk("loads", loads, e.loads);
            chk("clears", clrs, e.clear);
            chk("done_latency", n, e.clear + e.loads + 1);
            chk("shifter_out", sh_q, e.out);
            chk("busy_done", busy, 1);
         end
      end
      if (!seen) chk("done_timeout", 0, 1);
   endtask

   initial begin
      exp_t e;
      int w;
      int k;
      repeat (2) @(negedge clk);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
      chk("rst_sh", {sh_reset, sh_load, sh_d, sh_dir}, 0);
      chk("rst_cnt", shift_cnt, 0);
      reset = 1;
      repeat (10) begin
         @(negedge clk);
         chk("idle_load", sh_load, 0);
      end
      chk("idle_ready", cmd_ready, 1);
      issue(DIR_LEFT, 3, 16'h0005, 0, 0, w);
      watch(0, 1);
      chk("t2_out", sh_q, 16'h0005);
      issue(DIR_LEFT, 0, 16'hFFFF, 1, 0, w);
      watch(0, 1);
      chk("t3_out", sh_q, 16'h0000);
      issue(DIR_RIGHT, 20, 16'hA5C3, 0, 0, w);
      watch(0, 1);
      chk("t3_sat_cnt", shift_cnt, 16);
      issue(DIR_LEFT, 8, 16'h00FF, 0, 3, w);
      watch(3, 1);
      @(negedge clk);
      chk("t4_ready", cmd_ready, 1);
      chk("t4_done_gone", done, 0);
      issue(DIR_RIGHT, 5, 16'h0013, 1, 5, w);
      watch(5, 1);
      issue(DIR_LEFT, 4, 16'h000A, 0, 0, w);
      watch(0, 0);
      issue(DIR_RIGHT, 2, 16'h0003, 1, 0, w);
      chk("b2b_wait", w, 1);
      chk("b2b_gap_load", sh_load, 0);
      watch(0, 1);
      issue(DIR_LEFT, 10, 16'h0155, 0, 0, w);
      e = sb.pop_front();
      k = 0;
      repeat (4) begin
         @(negedge clk);
         cmd_valid = 0;
         chk("t6_load", sh_load, 1);
         chk("t6_d", sh_d, e.pattern[k]);
         k++;
      end
      reset = 0;
      @(negedge clk);
      chk("t6_load_off", sh_load, 0);
      chk("t6_cnt", shift_cnt, 0);
      chk("t6_ready", cmd_ready, 1);
      chk("t6_busy", busy, 0);
      chk("t6_done", done, 0);
      reset = 1;
      repeat (3) begin
         @(negedge clk);
         chk("t6_no_done", done, 0);
         chk("t6_no_load", sh_load, 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
